// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl
// Converts host commands (HALT / RUN / STEP n / CLEAR) into a registered
// enable for a positive-edge clock gate. Every cycle with en = 1 lets exactly
// one rising edge through to the gated domain. The block counts passed edges
// and pulses done when a step finishes or a run is halted.
module step_clock_ctrl #(
    parameter int CNT_W        = 16,
    parameter int RUN_ON_RESET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             halt_req,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_count,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_HALTED = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_STEP   = 2'b10;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [CNT_W-1:0] L_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);

    // Reset image depends on whether the core should free-run out of reset.
    localparam logic       L_EN_RST    = (RUN_ON_RESET != 0) ? 1'b1 : 1'b0;
    localparam logic [1:0] L_STATE_RST = (RUN_ON_RESET != 0) ? ST_RUN : ST_HALTED;

    logic [1:0]       r_state;
    logic             r_en;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_edge_count;
    logic [CNT_W-1:0] r_remaining;

    logic             w_cmd_ready;
    logic             w_accept;
    logic [1:0]       w_state_nxt;
    logic             w_en_nxt;
    logic             w_done_nxt;
    logic             w_clear;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic [CNT_W-1:0] w_edge_nxt;

    // Ready depends on state and on the op offered; halt_req blocks RUN/STEP from HALTED.
    always_comb begin
        w_cmd_ready = 1'b0;
        case (r_state)
            ST_HALTED: begin
                if (halt_req && ((cmd_op == OP_RUN) || (cmd_op == OP_STEP))) begin
                    w_cmd_ready = 1'b0;
                end else begin
                    w_cmd_ready = 1'b1;
                end
            end
            ST_RUN: begin
                if (cmd_op == OP_HALT) begin
                    w_cmd_ready = 1'b1;
                end else begin
                    w_cmd_ready = 1'b0;
                end
            end
            ST_STEP: begin
                w_cmd_ready = 1'b0;
            end
            default: begin
                w_cmd_ready = 1'b0;
            end
        endcase
    end

    assign w_accept = cmd_valid & w_cmd_ready;

    // Next-state, enable, done and step-countdown decisions.
    always_comb begin
        w_state_nxt     = r_state;
        w_en_nxt        = r_en;
        w_done_nxt      = 1'b0;
        w_clear         = 1'b0;
        w_remaining_nxt = r_remaining;
        case (r_state)
            ST_HALTED: begin
                w_en_nxt = 1'b0;
                if (w_accept) begin
                    case (cmd_op)
                        OP_RUN: begin
                            w_state_nxt = ST_RUN;
                            w_en_nxt    = 1'b1;
                        end
                        OP_STEP: begin
                            if (cmd_count != L_ZERO) begin
                                w_state_nxt     = ST_STEP;
                                w_remaining_nxt = cmd_count;
                                w_en_nxt        = 1'b1;
                            end else begin
                                // Zero-length step completes immediately.
                                w_done_nxt = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            w_clear = 1'b1;
                        end
                        OP_HALT: begin
                            w_done_nxt = 1'b0;
                        end
                        default: begin
                            w_done_nxt = 1'b0;
                        end
                    endcase
                end else begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_RUN: begin
                // The only op accepted in RUN is HALT.
                if (halt_req || w_accept) begin
                    w_state_nxt = ST_HALTED;
                    w_en_nxt    = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_en_nxt = 1'b1;
                end
            end
            ST_STEP: begin
                // <= 1 also catches an impossible zero so STEP can never hang.
                if (halt_req || (r_remaining <= L_ONE)) begin
                    w_state_nxt     = ST_HALTED;
                    w_en_nxt        = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_remaining_nxt = L_ZERO;
                end else begin
                    w_en_nxt        = 1'b1;
                    w_remaining_nxt = r_remaining - L_ONE;
                end
            end
            default: begin
                w_state_nxt     = ST_HALTED;
                w_en_nxt        = 1'b0;
                w_remaining_nxt = L_ZERO;
            end
        endcase
    end

    // Passed-edge counter: CLEAR beats the increment, wraps naturally.
    always_comb begin
        if (w_clear) begin
            w_edge_nxt = L_ZERO;
        end else if (r_en) begin
            w_edge_nxt = r_edge_count + L_ONE;
        end else begin
            w_edge_nxt = r_edge_count;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= L_STATE_RST;
            r_en         <= L_EN_RST;
            r_busy       <= L_EN_RST;
            r_done       <= 1'b0;
            r_edge_count <= L_ZERO;
            r_remaining  <= L_ZERO;
        end else begin
            r_state      <= w_state_nxt;
            r_en         <= w_en_nxt;
            r_busy       <= (w_state_nxt != ST_HALTED);
            r_done       <= w_done_nxt;
            r_edge_count <= w_edge_nxt;
            r_remaining  <= w_remaining_nxt;
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign en         = r_en;
    assign busy       = r_busy;
    assign done       = r_done;
    assign edge_count = r_edge_count;
    assign state      = r_state;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Self-checking bench for step_clock_ctrl: a vector table for the main
// command/response behaviour plus hand-written multi-cycle sequences.
// A simple latch-and-AND gate model counts edges seen by the gated domain.
module tb_step_clock_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_count;
    logic        halt_req;
    logic        en;
    logic        busy;
    logic        done;
    logic [15:0] edge_count;
    logic [1:0]  state;

    // Second instance with a 4-bit counter for the wrap check.
    logic        rst4_n;
    logic        v4;
    logic        rdy4;
    logic [1:0]  op4;
    logic [3:0]  cnt4;
    logic        hr4;
    logic        en4;
    logic        busy4;
    logic        done4;
    logic [3:0]  ecnt4;
    logic [1:0]  st4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    step_clock_ctrl #(.CNT_W(16), .RUN_ON_RESET(0)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .halt_req(halt_req), .en(en),
        .busy(busy), .done(done), .edge_count(edge_count), .state(state)
    );

    step_clock_ctrl #(.CNT_W(4), .RUN_ON_RESET(0)) dut4 (
        .clk(clk), .rst_n(rst4_n), .cmd_valid(v4), .cmd_ready(rdy4),
        .cmd_op(op4), .cmd_count(cnt4), .halt_req(hr4), .en(en4),
        .busy(busy4), .done(done4), .edge_count(ecnt4), .state(st4)
    );

    // Gate model: enable latched in the low phase, ANDed with clk.
    logic en_lat = 1'b0;
    int   gcount = 0;
    wire  gclk   = clk & en_lat;
    always @(negedge clk) en_lat <= en;
    always @(posedge gclk) gcount <= gcount + 1;

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [15:0] cnt;
        logic        hr;
        logic        rdy;
        logic        en;
        logic        busy;
        logic        done;
        logic [15:0] ecnt;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (called at posedge+1), sample ready mid-cycle,
    // then return at posedge+1 with the registered results visible.
    task automatic apply(input logic v, input logic [1:0] op, input logic [15:0] cnt,
                         input logic hr, output logic rdy_s);
        cmd_valid = v;
        cmd_op    = op;
        cmd_count = cnt;
        halt_req  = hr;
        #1;
        rdy_s = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_count = 16'd0;
        halt_req  = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic e_en, input logic e_busy,
                              input logic e_done, input int e_ecnt, input logic [1:0] e_st);
        check({tag, " en"},    int'(en),    int'(e_en));
        check({tag, " busy"},  int'(busy),  int'(e_busy));
        check({tag, " done"},  int'(done),  int'(e_done));
        check({tag, " edges"}, int'(edge_count), e_ecnt);
        check({tag, " state"}, int'(state), int'(e_st));
    endtask

    initial begin
        logic r;
        int   g0;
        int   en_hi;

        //        v     op     cnt     hr    rdy   en    busy  done  edges   st
        tbl[0]  = '{1'b1, 2'd2, 16'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 2'd2};
        tbl[1]  = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 2'd2};
        tbl[2]  = '{1'b1, 2'd1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 2'd2};
        tbl[3]  = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3, 2'd2};
        tbl[4]  = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd4, 2'd2};
        tbl[5]  = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5, 2'd0};
        tbl[6]  = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 2'd0};
        tbl[7]  = '{1'b1, 2'd2, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5, 2'd0};
        tbl[8]  = '{1'b1, 2'd2, 16'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd5, 2'd2};
        tbl[9]  = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd6, 2'd0};
        tbl[10] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd6, 2'd0};
        tbl[11] = '{1'b1, 2'd3, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0};
        tbl[12] = '{1'b1, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0};
        tbl[13] = '{1'b1, 2'd1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0};
        tbl[14] = '{1'b1, 2'd1, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 2'd1};
        tbl[15] = '{1'b1, 2'd1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 2'd1};
        tbl[16] = '{1'b1, 2'd2, 16'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 2'd1};
        tbl[17] = '{1'b1, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 2'd0};
        tbl[18] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 2'd0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 16'd0; halt_req = 1'b0;
        rst4_n = 1'b0; v4 = 1'b0; op4 = 2'b00; cnt4 = 4'd0; hr4 = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rst4_n = 1'b1;
        #1;
        check("reset ready", int'(cmd_ready), 1);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 0, 2'd0);
        check("reset dut4 state", int'(st4), 0);
        @(posedge clk);
        #1;
        check_outs("reset+1", 1'b0, 1'b0, 1'b0, 0, 2'd0);

        // Table-driven vectors.
        g0 = gcount;
        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].v, tbl[i].op, tbl[i].cnt, tbl[i].hr, r);
            check($sformatf("v%0d ready", i), int'(r), int'(tbl[i].rdy));
            check_outs($sformatf("v%0d", i), tbl[i].en, tbl[i].busy, tbl[i].done,
                       int'(tbl[i].ecnt), tbl[i].st);
        end
        check("table gated edges", gcount - g0, 9);

        // Run, ten cycles, then halt_req with a colliding RUN command.
        apply(1'b1, 2'd3, 16'd0, 1'b0, r);
        g0 = gcount;
        apply(1'b1, 2'd1, 16'd0, 1'b0, r);
        check_outs("run start", 1'b1, 1'b1, 1'b0, 0, 2'd1);
        for (int i = 0; i < 10; i++) apply(1'b0, 2'd0, 16'd0, 1'b0, r);
        apply(1'b1, 2'd1, 16'd0, 1'b1, r);
        check("halt cycle ready", int'(r), 0);
        check_outs("run halted", 1'b0, 1'b0, 1'b1, 11, 2'd0);
        check("run gated edges", gcount - g0, 11);
        apply(1'b0, 2'd0, 16'd0, 1'b0, r);
        check_outs("run after", 1'b0, 1'b0, 1'b0, 11, 2'd0);

        // STEP 100 aborted by halt_req on the 40th enabled cycle.
        apply(1'b1, 2'd3, 16'd0, 1'b0, r);
        apply(1'b1, 2'd2, 16'd100, 1'b0, r);
        en_hi = 0;
        for (int i = 0; i < 39; i++) begin
            if (en) en_hi++;
            apply(1'b0, 2'd0, 16'd0, 1'b0, r);
        end
        if (en) en_hi++;
        check("abort en-high cycles", en_hi, 40);
        apply(1'b0, 2'd0, 16'd0, 1'b1, r);
        check_outs("abort", 1'b0, 1'b0, 1'b1, 40, 2'd0);
        apply(1'b1, 2'd3, 16'd0, 1'b0, r);
        check_outs("clear", 1'b0, 1'b0, 1'b0, 0, 2'd0);

        // Counter wrap on the 4-bit instance: 20 enabled cycles.
        v4 = 1'b1; op4 = 2'd1;
        @(posedge clk);
        #1;
        v4 = 1'b0; op4 = 2'd0;
        check("wrap run state", int'(st4), 1);
        repeat (19) @(posedge clk);
        #1;
        v4 = 1'b1; op4 = 2'd0;
        @(posedge clk);
        #1;
        v4 = 1'b0;
        check("wrap edges", int'(ecnt4), 4);
        check("wrap state", int'(st4), 0);
        check("wrap done", int'(done4), 1);

        // Reset asserted in the third cycle of STEP 8.
        apply(1'b1, 2'd2, 16'd8, 1'b0, r);
        apply(1'b0, 2'd0, 16'd0, 1'b0, r);
        apply(1'b0, 2'd0, 16'd0, 1'b0, r);
        check("mid-step edges before reset", int'(edge_count), 2);
        rst_n = 1'b0;
        apply(1'b0, 2'd0, 16'd0, 1'b0, r);
        rst_n = 1'b1;
        check_outs("midreset", 1'b0, 1'b0, 1'b0, 0, 2'd0);
        g0 = gcount;
        apply(1'b0, 2'd0, 16'd0, 1'b0, r);
        check_outs("midreset+1", 1'b0, 1'b0, 1'b0, 0, 2'd0);
        check("midreset gated edges", gcount - g0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/step_clock_ctrl.md
Name: step_clock_ctrl

Overview:
- Drives the enable input of the positive-edge gate. Gate and controller share the free-running `clk`, and the controller's output is the gate's `en`.
- Turns host commands (halt, free-run, step N edges, clear) into an enable waveform that passes exactly the requested number of rising edges to the gated CPU clock domain.
- Counts the edges it has let through and reports completion with a done pulse.
- Sits between the debug/front-panel host logic and the edge gate, at the root of the gated clock tree.

Parameters:
CNT_W, 16, width of the step count and of the passed-edge counter
RUN_ON_RESET, 0, if 1 the controller leaves reset in RUN; if 0 it leaves reset in HALTED

Ports:
clk  input  1  free-running clock, the same net that feeds the edge gate clk input
rst_n  input  1  reset, synchronous, active-low
cmd_valid  input  1  host command present
cmd_ready  output  1  controller accepts the command this cycle
cmd_op  input  2  00 HALT, 01 RUN, 10 STEP, 11 CLEAR
cmd_count  input  CNT_W  number of edges for STEP
halt_req  input  1  synchronous halt request from the gated domain (halt instruction, breakpoint)
en  output  1  registered enable to the edge gate
busy  output  1  1 in RUN or STEP
done  output  1  one-cycle pulse when STEP completes or RUN is halted
edge_count  output  CNT_W  number of rising edges passed since the last CLEAR or reset
state  output  2  00 HALTED, 01 RUN, 10 STEP

Behaviour:
- Clock and reset: single clock domain. Everything updates on the rising edge of `clk`. Reset is synchronous and active-low.
- Reset values:
  - state = HALTED, or RUN if RUN_ON_RESET = 1.
  - en = RUN_ON_RESET.
  - done = 0.
  - edge_count = 0.
  - Internal remaining-step counter = 0.
- Enable timing:
  - `en` comes straight from a flop and changes only just after a rising edge, so it is stable through the whole low phase in which the gate samples it.
  - If en = 1 during cycle k, the rising edge that ends cycle k is passed. Each cycle with en = 1 is exactly one passed edge.
- Edge counting: edge_count increments by 1 in every cycle where en = 1 and wraps modulo 2^CNT_W. No saturation.
- Handshake: a command is accepted when cmd_valid and cmd_ready are both 1.
  - cmd_ready = 1 in HALTED.
  - cmd_ready = 1 in RUN, for HALT only.
  - cmd_ready = 0 in STEP. A STEP cannot be aborted by command; only halt_req or reset ends it early.
  - An unsupported op in the current state holds cmd_ready = 0, so the host waits.
- HALTED state:
  - RUN: next state RUN, en = 1 from the next cycle.
  - STEP with N > 0: next state STEP, remaining = N, en = 1 for exactly N consecutive cycles.
  - STEP with N = 0: stays HALTED, done pulses next cycle, no edges passed.
  - CLEAR: edge_count = 0 next cycle. If the increment condition also holds that cycle, CLEAR wins.
  - HALT: no-op, done stays 0.
- RUN state:
  - en held at 1.
  - An accepted HALT or halt_req = 1 sets next state HALTED, en = 0 next cycle, done pulses.
  - The edge ending the cycle in which halt is observed is still passed, because en was already 1.
- STEP state:
  - remaining decrements each cycle.
  - When remaining reaches 1, the next state is HALTED, en = 0, and done pulses in the first HALTED cycle.
  - halt_req = 1 ends the step early the same way. edge_count then shows the edges actually passed.
- Priority: reset > halt_req > accepted command > step countdown.
- halt_req in HALTED: ignored, no done pulse. A simultaneous cmd_valid RUN or STEP is not accepted that cycle (cmd_ready = 0).
- done: exactly one cycle wide per completion, never asserted while busy = 1.
- Reset mid-operation: en drops in the first cycle after the reset edge and no further edges pass. state, edge_count and remaining return to their reset values. A partly counted STEP is discarded.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles, then release (RUN_ON_RESET = 0) -> state = 00, en = 0, edge_count = 0, cmd_ready = 1, done = 0.
- Step 5: accept STEP N = 5 from HALTED -> en = 1 for exactly 5 cycles; edge_count goes 0 to 5; done pulses once on the cycle en returns to 0; a gated-clock edge count at the gate output is also 5.
- Step 0: STEP N = 0 -> en never rises, done pulses the next cycle, edge_count unchanged; a STEP N = 1 immediately after gives exactly one en-high cycle.
- Run then halt: RUN, wait 10 cycles, pulse halt_req for 1 cycle -> edge_count = 11 (halt-cycle edge included), done pulses, state = 00; a cmd_valid RUN in the same cycle as halt_req is not accepted.
- Early abort and counter rules: STEP N = 100, halt_req at the 40th en-high cycle -> stop with edge_count = 40. CLEAR -> 0. With CNT_W = 4, RUN for 20 cycles -> edge_count = 4 (wrapped).
- Reset mid-step: rst_n = 0 during the 3rd cycle of STEP N = 8 -> en = 0 from the next cycle, no done pulse, edge_count = 0, state = 00.
